// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: queues bytes in a TX FIFO, launches them one at a time into
// an external spi_master and collects the received bytes into an RX FIFO.
// A launch is only issued when RX has a free slot, so RX can never overflow.
module spi_burst_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     tx_wr_en,
    input  logic [7:0]               tx_wr_data,
    output logic                     tx_full,
    output logic [$clog2(DEPTH):0]   tx_level,
    input  logic                     rx_rd_en,
    output logic [7:0]               rx_rd_data,
    output logic                     rx_empty,
    output logic                     tx_ovf,
    output logic                     active,
    output logic                     spi_start,
    output logic [7:0]               spi_tx_data,
    input  logic                     spi_busy,
    input  logic                     spi_done,
    input  logic [7:0]               spi_rx_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_MAX = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, XFER, CAPTURE} state_t;

    state_t          state;
    logic [7:0]      tx_mem [DEPTH];
    logic [7:0]      rx_mem [DEPTH];
    logic [AW-1:0]   tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [AW:0]     tx_cnt, rx_cnt;
    logic            done_q;

    logic tx_empty, rx_full, launch, tx_push, rx_push, rx_pop, done_rise;

    assign tx_empty   = (tx_cnt == '0);
    assign tx_full    = (tx_cnt == CNT_MAX);
    assign tx_level   = tx_cnt;
    assign rx_empty   = (rx_cnt == '0);
    assign rx_full    = (rx_cnt == CNT_MAX);
    assign rx_rd_data = rx_mem[rx_rptr];

    // A held-high done from a previous transfer does not count: only 0->1.
    assign done_rise = spi_done && !done_q;
    assign launch    = (state == IDLE) && en && !tx_empty && !rx_full && !spi_busy;
    // At full, a write is still accepted if the head leaves on the same edge.
    assign tx_push   = tx_wr_en && (!tx_full || launch);
    assign rx_push   = (state == XFER) && done_rise;
    assign rx_pop    = rx_rd_en && !rx_empty;

    // TX storage write
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= tx_wr_data;
    end

    // RX storage write
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr] <= spi_rx_data;
    end

    // TX pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
            tx_ovf  <= 1'b0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (launch)  tx_rptr <= tx_rptr + 1'b1;
            if (tx_push && !launch)      tx_cnt <= tx_cnt + 1'b1;
            else if (!tx_push && launch) tx_cnt <= tx_cnt - 1'b1;
            if (tx_wr_en && tx_full && !launch) tx_ovf <= 1'b1;
        end
    end

    // RX pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
        end
    end

    // Transfer sequencer with registered start/active/data outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            spi_start   <= 1'b0;
            active      <= 1'b0;
            spi_tx_data <= 8'h00;
            done_q      <= 1'b0;
        end else begin
            done_q <= spi_done;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state       <= LAUNCH;
                        spi_tx_data <= tx_mem[tx_rptr];
                        spi_start   <= 1'b1;
                        active      <= 1'b1;
                    end
                end
                LAUNCH: begin
                    spi_start <= 1'b0;
                    state     <= XFER;
                end
                XFER: begin
                    if (done_rise) begin
                        state  <= CAPTURE;
                        active <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_spi_burst_ctrl;

    localparam int DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   en = 1'b0;
    logic                   tx_wr_en = 1'b0;
    logic [7:0]             tx_wr_data = 8'h00;
    logic                   rx_rd_en = 1'b0;
    logic                   spi_busy = 1'b0;
    logic                   spi_done = 1'b0;
    logic [7:0]             spi_rx_data = 8'h00;
    logic                   tx_full;
    logic [$clog2(DEPTH):0] tx_level;
    logic [7:0]             rx_rd_data;
    logic                   rx_empty;
    logic                   tx_ovf;
    logic                   active;
    logic                   spi_start;
    logic [7:0]             spi_tx_data;

    spi_burst_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .en(en),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
        .tx_full(tx_full), .tx_level(tx_level),
        .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty),
        .tx_ovf(tx_ovf), .active(active),
        .spi_start(spi_start), .spi_tx_data(spi_tx_data),
        .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx_data(spi_rx_data)
    );

    always #5 clk = ~clk;

    // Loopback spi_master stand-in: busy for lat+1 cycles, then returns the
    // launched byte with done high (one cycle, or held until next start).
    logic       hold_done = 1'b0;
    int         lat = 1;
    int         scnt = 0;
    logic [7:0] sbyte = 8'h00;
    int         start_cnt = 0;

    always @(posedge clk) begin
        if (spi_start) begin
            start_cnt <= start_cnt + 1;
            spi_busy  <= 1'b1;
            scnt      <= lat;
            sbyte     <= spi_tx_data;
            spi_done  <= 1'b0;
        end else if (spi_busy) begin
            if (scnt == 0) begin
                spi_busy    <= 1'b0;
                spi_done    <= 1'b1;
                spi_rx_data <= sbyte;
            end else begin
                scnt <= scnt - 1;
            end
        end else if (!hold_done) begin
            spi_done <= 1'b0;
        end
    end

    int pass_cnt = 0;
    int total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        tx_wr_en   = 1'b1;
        tx_wr_data = d;
        step();
        tx_wr_en   = 1'b0;
    endtask

    task automatic pop_expect(input string nm, input logic [7:0] exp);
        int n = 0;
        while (rx_empty && n < 200) begin
            step();
            n++;
        end
        chk({nm, " nonempty"}, rx_empty, 0);
        chk({nm, " data"}, rx_rd_data, exp);
        rx_rd_en = 1'b1;
        step();
        rx_rd_en = 1'b0;
    endtask

    task automatic do_reset();
        tx_wr_en = 1'b0;
        rx_rd_en = 1'b0;
        en       = 1'b0;
        reset    = 1'b1;
        step();
        step();
        reset    = 1'b0;
    endtask

    // Reference model for random traffic: TX contents, bytes launched but not
    // yet read back (RX contents plus the one in flight), sticky overflow.
    logic [7:0] tq[$];
    logic [7:0] lq[$];
    bit         movf;
    logic [7:0] last_tx;

    task automatic rand_cycle(input bit w, input logic [7:0] d, input bit r, input bit e);
        int         pre;
        bit         re;
        logic [7:0] rd_pre;
        logic [7:0] exp;
        bit         pop;
        tx_wr_en   = w;
        tx_wr_data = d;
        rx_rd_en   = r;
        en         = e;
        pre    = tq.size();
        re     = rx_empty;
        rd_pre = rx_rd_data;
        step();
        pop = spi_start;
        if (r && !re) begin
            if (lq.size() == 0) chk("rnd rx spurious", re, 1);
            else chk("rnd rx data", rd_pre, lq.pop_front());
        end
        if (pop) begin
            if (tq.size() == 0) begin
                total++;
                $display("FAIL rnd launch from empty tx: got start expected none");
            end else begin
                exp = tq.pop_front();
                chk("rnd launch byte", spi_tx_data, exp);
                last_tx = exp;
                lq.push_back(exp);
                chk("rnd rx slot", lq.size() <= DEPTH, 1);
            end
        end
        if (w) begin
            if (pre < DEPTH || pop) tq.push_back(d);
            else movf = 1'b1;
        end
        chk("rnd tx_level", tx_level, tq.size());
        chk("rnd tx_full", tx_full, tq.size() == DEPTH);
        chk("rnd tx_ovf", tx_ovf, movf);
        chk("rnd tx hold", spi_tx_data, last_tx);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic [3:0] lvl;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t tbl[9];
    int   s0;

    initial begin
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 8'(i + 1), 4'(i + 1), (i == 7), 1'b0};
        tbl[8] = '{1'b1, 8'h09, 4'd8, 1'b1, 1'b1};

        // reset state
        step();
        step();
        chk("rst tx_level", tx_level, 0);
        chk("rst tx_full", tx_full, 0);
        chk("rst rx_empty", rx_empty, 1);
        chk("rst tx_ovf", tx_ovf, 0);
        chk("rst active", active, 0);
        chk("rst spi_start", spi_start, 0);
        chk("rst spi_tx_data", spi_tx_data, 8'h00);
        reset = 1'b0;

        // single loopback byte
        lat = 4;
        s0 = start_cnt;
        push(8'hA5);
        en = 1'b1;
        pop_expect("loopback", 8'hA5);
        repeat (10) step();
        chk("loopback starts", start_cnt - s0, 1);
        chk("loopback active", active, 0);
        en = 1'b0;
        lat = 1;

        // fill TX with en low, then overflow, then drain in order
        for (int i = 0; i < 9; i++) begin
            tx_wr_en   = tbl[i].wr;
            tx_wr_data = tbl[i].d;
            step();
            chk("tbl tx_level", tx_level, tbl[i].lvl);
            chk("tbl tx_full", tx_full, tbl[i].full);
            chk("tbl tx_ovf", tx_ovf, tbl[i].ovf);
        end
        tx_wr_en = 1'b0;
        en = 1'b1;
        for (int i = 1; i <= 8; i++) pop_expect("drain", 8'(i));
        repeat (30) step();
        chk("drain no 9th", rx_empty, 1);
        chk("drain tx_level", tx_level, 0);
        chk("ovf sticky", tx_ovf, 1);
        do_reset();
        chk("ovf cleared", tx_ovf, 0);

        // RX full blocks launch until one slot is read
        en = 1'b1;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        repeat (120) step();
        chk("rxfull tx drained", tx_level, 0);
        push(8'h55);
        s0 = start_cnt;
        repeat (30) step();
        chk("rxfull held", tx_level, 1);
        chk("rxfull no start", start_cnt - s0, 0);
        pop_expect("rxfull first", 8'h10);
        repeat (30) step();
        chk("rxfull launched", start_cnt - s0, 1);
        for (int i = 1; i < 8; i++) pop_expect("rxfull", 8'h10 + 8'(i));
        pop_expect("rxfull 55", 8'h55);
        step();
        chk("rxfull exactly 8", rx_empty, 1);
        en = 1'b0;

        // done held high by the master: one capture per launch
        hold_done = 1'b1;
        s0 = start_cnt;
        en = 1'b1;
        push(8'h61);
        push(8'h62);
        repeat (40) step();
        chk("hold starts", start_cnt - s0, 2);
        pop_expect("hold a", 8'h61);
        pop_expect("hold b", 8'h62);
        repeat (5) step();
        chk("hold single push", rx_empty, 1);
        hold_done = 1'b0;
        en = 1'b0;
        repeat (3) step();

        // reset during transfer discards the in-flight byte
        lat = 8;
        en = 1'b1;
        push(8'h3C);
        for (int n = 0; n < 20 && !(active && !spi_start); n++) step();
        chk("abort in xfer", active && !spi_start, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort tx_level", tx_level, 0);
        chk("abort tx_full", tx_full, 0);
        chk("abort rx_empty", rx_empty, 1);
        chk("abort tx_ovf", tx_ovf, 0);
        chk("abort active", active, 0);
        chk("abort spi_start", spi_start, 0);
        chk("abort spi_tx_data", spi_tx_data, 8'h00);
        step();
        step();
        reset = 1'b0;
        s0 = start_cnt;
        repeat (30) step();
        chk("abort no capture", rx_empty, 1);
        chk("abort no start", start_cnt - s0, 0);
        lat = 1;
        push(8'h3D);
        pop_expect("abort new", 8'h3D);
        en = 1'b0;
        repeat (5) step();

        // write at full on the same edge as a launch pop
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        chk("same full", tx_full, 1);
        en         = 1'b1;
        tx_wr_en   = 1'b1;
        tx_wr_data = 8'h28;
        step();
        tx_wr_en   = 1'b0;
        chk("same start", spi_start, 1);
        chk("same level", tx_level, 8);
        chk("same no ovf", tx_ovf, 0);
        for (int i = 0; i < 9; i++) pop_expect("same", 8'h20 + 8'(i));
        en = 1'b0;

        // randomized traffic
        for (int seg = 0; seg < 10; seg++) begin
            int wr_pct;
            hold_done = 1'($urandom_range(0, 1));
            lat       = int'($urandom_range(0, 3));
            wr_pct    = (seg % 3 == 0) ? 10 : (seg % 3 == 1) ? 30 : 60;
            do_reset();
            tq.delete();
            lq.delete();
            movf    = 1'b0;
            last_tx = 8'h00;
            for (int c = 0; c < 250; c++)
                rand_cycle($urandom_range(0, 99) < wr_pct, 8'($urandom),
                           $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 300; c++) rand_cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("rnd drain tx", tq.size(), 0);
        chk("rnd drain rx", lq.size(), 0);
        chk("rnd drain rx_empty", rx_empty, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/spi_burst_ctrl.md
SPI_BURST_CTRL -- requirements
Module: spi_burst_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, entries per FIFO (power of two, 2..64).
REQ-002 Port clk  input  1  single clock for all state; rising-edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port en  input  1  when high, queued bytes may launch.
REQ-005 Port tx_wr_en  input  1  push tx_wr_data into TX FIFO.
REQ-006 Port tx_wr_data  input  8  byte to transmit.
REQ-007 Port tx_full  output  1  TX FIFO holds DEPTH entries.
REQ-008 Port tx_level  output  clog2(DEPTH)+1  TX FIFO occupancy.
REQ-009 Port rx_rd_en  input  1  pop head of RX FIFO.
REQ-010 Port rx_rd_data  output  8  RX FIFO head, first-word-fall-through.
REQ-011 Port rx_empty  output  1  RX FIFO holds zero entries.
REQ-012 Port tx_ovf  output  1  sticky: write attempted while TX full.
REQ-013 Port active  output  1  a byte is launched and not yet captured.
REQ-014 Port spi_start  output  1  one-cycle start pulse to spi_master.
REQ-015 Port spi_tx_data  output  8  byte presented to spi_master.
REQ-016 Port spi_busy  input  1  spi_master busy.
REQ-017 Port spi_done  input  1  spi_master done.
REQ-018 Port spi_rx_data  input  8  spi_master received byte.

Function
REQ-019 FSM states IDLE, LAUNCH, XFER, CAPTURE; encoding free.
REQ-020 IDLE->LAUNCH when en=1, TX non-empty, RX has at least one free slot, spi_busy=0; TX head popped same edge into spi_tx_data register.
REQ-021 LAUNCH: spi_start=1 for exactly one cycle; next state XFER.
REQ-022 XFER: wait for rising edge of spi_done (registered previous-value compare); a level-high done left over from an earlier transfer is not an edge.
REQ-023 On spi_done rising edge: XFER->CAPTURE; spi_rx_data sampled that cycle and pushed into RX FIFO.
REQ-024 CAPTURE lasts one cycle, then IDLE; minimum launch-to-launch spacing therefore 4 cycles plus master transfer time.
REQ-025 spi_tx_data SHALL stay stable from LAUNCH until next LAUNCH.
REQ-026 active=1 in LAUNCH and XFER, 0 otherwise.
REQ-027 en deasserted mid-transfer: in-flight byte completes and is captured; no new launch.
REQ-028 TX write while full (and no same-cycle pop): data dropped, tx_ovf set until reset.
REQ-029 TX write and pop same cycle at full: both occur, level unchanged, no overflow.
REQ-030 rx_rd_en while empty: ignored, pointers unchanged.
REQ-031 RX push and pop same cycle: both occur, level unchanged.
REQ-032 RX overflow impossible: launch gated on free RX slot (REQ-020).
REQ-033 FIFO pointers wrap modulo DEPTH; level counters saturate never exceed DEPTH.
REQ-034 rx_rd_data undefined-but-stable when rx_empty=1; no X propagation required to be masked.

Reset
REQ-035 reset=1 asynchronously: state IDLE, both FIFOs empty, tx_level=0, tx_full=0, rx_empty=1, tx_ovf=0, active=0, spi_start=0, spi_tx_data=8'h00, done-edge register 0.
REQ-036 Reset asserted mid-transfer aborts; byte in flight is discarded, not captured after release.
REQ-037 First launch possible no earlier than the second rising clk edge after reset deassertion.

Verification
REQ-038 Loopback with spi_master (clk_div=4, miso=mosi): push 8'hA5, en=1 -> exactly one spi_start pulse, RX head reads 8'hA5, active returns 0.
REQ-039 Push 8'h01..8'h08 (DEPTH=8) with en=0 -> tx_full=1, tx_level=8; 9th write -> tx_ovf=1, level stays 8; en=1 -> RX yields 01..08 in order, no 9th byte.
REQ-040 Fill RX to 8 without reading, TX holds 8'h55 -> no launch; single rx_rd_en -> 8'h55 launched and captured, RX level back to 8.
REQ-041 spi_done held high across CAPTURE/IDLE by stub master -> only one RX push per launch.
REQ-042 Reset asserted during XFER of 8'h3C -> all outputs at REQ-035 values, rx_empty stays 1 after release, no spi_start until new data queued.
REQ-043 Simultaneous tx_wr_en at full plus internal pop -> tx_ovf stays 0, written byte later appears on RX.
